// File: rtl/ntt_stride_permutation_if.sv
// Stream bundle for ntt_stride_permutation: natural-order input beats in, permuted beats out.
interface ntt_stride_permutation_if #(
  parameter int unsigned DATA_WIDTH_PER_INPUT = 28,
  parameter int unsigned INPUT_PER_CYCLE      = 32
);
  logic                            in_start;
  logic                            in_mode;
  logic [DATA_WIDTH_PER_INPUT-1:0] inData  [INPUT_PER_CYCLE-1:0];
  logic [DATA_WIDTH_PER_INPUT-1:0] outData [INPUT_PER_CYCLE-1:0];
  logic                            out_start;
  logic                            out_valid;

  modport master (output in_start, in_mode, inData, input outData, out_start, out_valid);
  modport slave  (input in_start, in_mode, inData, output outData, out_start, out_valid);
endinterface

// File: rtl/ntt_stride_permutation.sv
// Ping-pong streaming stride permutation for the NTT datapath.
// Define NTT_PERM_BITREV_EN to add the per-frame bit-reverse mode selected by in_mode.
module ntt_stride_permutation #(
  parameter int unsigned DATA_WIDTH_PER_INPUT = 28,
  parameter int unsigned INPUT_PER_CYCLE      = 32,
  parameter int unsigned FRAME_SIZE           = 1024,
  parameter int unsigned STRIDE               = 32
) (
  input logic                     clk,
  input logic                     rst,
  ntt_stride_permutation_if.slave bus_io
);
  localparam int unsigned Beats = FRAME_SIZE / INPUT_PER_CYCLE;
  localparam int unsigned LogN  = $clog2(FRAME_SIZE);
  localparam int unsigned LogP  = $clog2(INPUT_PER_CYCLE);
  localparam int unsigned LogB  = LogN - LogP;
  localparam int unsigned LogS  = $clog2(STRIDE);

  typedef logic [DATA_WIDTH_PER_INPUT-1:0] data_t;
  typedef logic [LogN-1:0]                 idx_t;
  typedef logic [LogB-1:0]                 beat_t;
  typedef enum logic [0:0] {StIdle, StRead} state_e;

  // (k mod S)*(N/S) + k/S is a rotation of k's index bits by log2(S).
  function automatic idx_t stride_src(idx_t k);
    return {k[LogS-1:0], k[LogN-1:LogS]};
  endfunction

`ifdef NTT_PERM_BITREV_EN
  function automatic idx_t bitrev_src(idx_t k);
    idx_t r;
    for (int i = 0; i < int'(LogN); i++) r[i] = k[int'(LogN)-1-i];
    return r;
  endfunction
`endif

  data_t      mem_q [2][FRAME_SIZE];
  logic       wbusy_q;
  beat_t      wcnt_q;
  logic       wbank_q;
  logic [1:0] full_q, full_d;
  logic       wen, wlast;
  beat_t      waddr;

  state_e     state_q, state_d;
  beat_t      rcnt_q, rcnt_d;
  logic       rbank_q, rbank_d;
  logic       nbank, rlast, take;

  data_t      out_data_q [INPUT_PER_CYCLE-1:0];
  data_t      out_data_d [INPUT_PER_CYCLE-1:0];
  logic       out_start_q, out_start_d;
  logic       out_valid_q, out_valid_d;

  // Write side: in_start always restarts capture at beat 0, discarding any partial frame.
  always_comb begin
    wen   = bus_io.in_start | wbusy_q;
    waddr = bus_io.in_start ? '0 : wcnt_q;
    wlast = wen && (waddr == beat_t'(Beats - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbusy_q <= 1'b0;
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
      full_q  <= '0;
    end else begin
      full_q <= full_d;
      if (wlast) begin
        wbusy_q <= 1'b0;
        wcnt_q  <= '0;
        wbank_q <= ~wbank_q;
      end else if (wen) begin
        wbusy_q <= 1'b1;
        wcnt_q  <= waddr + beat_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wen) begin
      for (int j = 0; j < int'(INPUT_PER_CYCLE); j++) begin
        mem_q[wbank_q][{waddr, LogP'(j)}] <= bus_io.inData[j];
      end
    end
  end

  always_comb begin
    full_d = full_q;
    if (wlast) full_d[wbank_q] = 1'b1;
    if (take)  full_d[nbank]   = 1'b0;
  end

`ifdef NTT_PERM_BITREV_EN
  logic [1:0] bank_mode_q;
  logic       rmode_q;

  // Mode travels with the bank being written; the reader latches it when taking the bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_mode_q <= '0;
      rmode_q     <= 1'b0;
    end else begin
      if (bus_io.in_start) bank_mode_q[wbank_q] <= bus_io.in_mode;
      if (take)            rmode_q <= bank_mode_q[nbank];
    end
  end
`endif

  // Banks are read in the order written, so the next bank to read is always the other one.
  assign nbank = ~rbank_q;
  assign rlast = (rcnt_q == beat_t'(Beats - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rcnt_q  <= '0;
      rbank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      rbank_q <= rbank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    take    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (full_q[nbank]) take = 1'b1;
      end
      StRead: begin
        rcnt_d = rcnt_q + beat_t'(1);
        if (rlast) begin
          if (full_q[nbank]) take = 1'b1;
          else               state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (take) begin
      state_d = StRead;
      rcnt_d  = '0;
      rbank_d = nbank;
    end
  end

  always_comb begin
    out_valid_d = (state_q == StRead);
    out_start_d = (state_q == StRead) && (rcnt_q == '0);
    for (int j = 0; j < int'(INPUT_PER_CYCLE); j++) begin
      out_data_d[j] = '0;
      if (state_q == StRead) begin
`ifdef NTT_PERM_BITREV_EN
        out_data_d[j] = mem_q[rbank_q][rmode_q ? bitrev_src({rcnt_q, LogP'(j)})
                                               : stride_src({rcnt_q, LogP'(j)})];
`else
        out_data_d[j] = mem_q[rbank_q][stride_src({rcnt_q, LogP'(j)})];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      for (int j = 0; j < int'(INPUT_PER_CYCLE); j++) out_data_q[j] <= '0;
    end else begin
      out_start_q <= out_start_d;
      out_valid_q <= out_valid_d;
      for (int j = 0; j < int'(INPUT_PER_CYCLE); j++) out_data_q[j] <= out_data_d[j];
    end
  end

  assign bus_io.outData   = out_data_q;
  assign bus_io.out_start = out_start_q;
  assign bus_io.out_valid = out_valid_q;
endmodule

// File: tb/tb_ntt_stride_permutation.sv
// Bench for ntt_stride_permutation: default 1024/32/32 instance plus a 16/4/2 instance.
module tb_ntt_stride_permutation;
  localparam int unsigned DW  = 28;
  localparam int unsigned P   = 32;
  localparam int unsigned N   = 1024;
  localparam int unsigned S   = 32;
  localparam int unsigned B   = N / P;
  localparam int unsigned SDW = 8;
  localparam int unsigned SP  = 4;
  localparam int unsigned SN  = 16;
  localparam int unsigned SS  = 2;
  localparam int unsigned SB  = SN / SP;

`ifdef NTT_PERM_BITREV_EN
  localparam bit BitrevOn = 1'b1;
`else
  localparam bit BitrevOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_stride_permutation_if #(.DATA_WIDTH_PER_INPUT(DW), .INPUT_PER_CYCLE(P)) bus ();
  ntt_stride_permutation_if #(.DATA_WIDTH_PER_INPUT(SDW), .INPUT_PER_CYCLE(SP)) sbus ();

  ntt_stride_permutation #(
    .DATA_WIDTH_PER_INPUT(DW), .INPUT_PER_CYCLE(P), .FRAME_SIZE(N), .STRIDE(S)
  ) dut (
    .clk(clk), .rst(rst), .bus_io(bus)
  );

  ntt_stride_permutation #(
    .DATA_WIDTH_PER_INPUT(SDW), .INPUT_PER_CYCLE(SP), .FRAME_SIZE(SN), .STRIDE(SS)
  ) sdut (
    .clk(clk), .rst(rst), .bus_io(sbus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0]  frm [N];
  logic [DW-1:0]  exp_q [$];
  logic [DW-1:0]  out_q [$];
  int             start_q [$];
  int             vcyc_q [$];
  logic [SDW-1:0] sout_q [$];
  int             sstart_q [$];

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      for (int j = 0; j < int'(P); j++) out_q.push_back(bus.outData[j]);
      vcyc_q.push_back(cyc);
    end
    if (bus.out_start === 1'b1) start_q.push_back(cyc);
    if (sbus.out_valid === 1'b1) begin
      for (int j = 0; j < int'(SP); j++) sout_q.push_back(sbus.outData[j]);
    end
    if (sbus.out_start === 1'b1) sstart_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference permutation taken straight from the index formulas.
  function automatic int unsigned model_src(int unsigned k, bit brev);
    int unsigned r  = 0;
    int unsigned kk = k;
    if (!brev) return (k % S) * (N / S) + k / S;
    for (int i = 0; i < $clog2(N); i++) begin
      r  = r * 2 + kk % 2;
      kk = kk / 2;
    end
    return r;
  endfunction

  function automatic void push_expected(input bit mode);
    for (int k = 0; k < int'(N); k++) exp_q.push_back(frm[model_src(k, mode && BitrevOn)]);
  endfunction

  task automatic fill(input bit rnd, input int unsigned offs);
    for (int i = 0; i < int'(N); i++) frm[i] = rnd ? DW'($urandom) : DW'(i + offs);
  endtask

  task automatic clear_all();
    out_q.delete(); start_q.delete(); vcyc_q.delete(); exp_q.delete();
  endtask

  task automatic send(input bit mode, input int nbeats, output int t0);
    t0 = 0;
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      if (b == 0) t0 = cyc + 1;
      bus.in_start = (b == 0);
      bus.in_mode  = (b == 0) ? mode : 1'($urandom);
      for (int j = 0; j < int'(P); j++) bus.inData[j] = frm[b * P + j];
    end
  endtask

  task automatic wait_out(input int n_elems, input string tag);
    int k = 0;
    while (out_q.size() < n_elems && k < 8 * int'(B) + 50) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    chk({tag, " elem count"}, out_q.size(), n_elems);
  endtask

  task automatic cmp_frames(input string tag);
    int nbad  = 0;
    int first = 0;
    for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
      if (out_q[k] !== exp_q[k]) begin
        if (nbad == 0) first = k;
        nbad++;
      end
    end
    total++;
    assert (nbad === 0) else begin
      bad++;
      $error("FAIL %s: %0d elements differ, first k=%0d observed %0h expected %0h",
             tag, nbad, first, out_q[first], exp_q[first]);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    logic [DW-1:0] any = '0;
    for (int j = 0; j < int'(P); j++) any |= bus.outData[j];
    chk({tag, " out_valid"}, bus.out_valid, 0);
    chk({tag, " out_start"}, bus.out_start, 0);
    chk({tag, " outData"}, any, 0);
  endtask

  initial begin
    int t0, t1, k;
    logic [SDW-1:0] sexp [SN];
    logic [31:0]    sobs, sref;
    sexp = '{0, 8, 1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 14, 7, 15};

    bus.in_start = 1'b0;
    bus.in_mode  = 1'b0;
    for (int j = 0; j < int'(P); j++) bus.inData[j] = '0;
    sbus.in_start = 1'b0;
    sbus.in_mode  = 1'b0;
    for (int j = 0; j < int'(SP); j++) sbus.inData[j] = '0;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset small out_valid", sbus.out_valid, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no spurious out_start", start_q.size(), 0);

    // Ramp frame, stride mode
    clear_all();
    fill(1'b0, 0);
    send(1'b0, B, t0);
    push_expected(1'b0);
    wait_out(N, "ramp stride");
    chk("ramp stride starts", start_q.size(), 1);
    chk("ramp stride latency", start_q[0] - t0, B + 1);
    chk("ramp stride b0l1", out_q[1], 32);
    chk("ramp stride b1l1", out_q[P + 1], 33);
    chk("ramp stride b31l31", out_q[N - 1], 1023);
    cmp_frames("ramp stride frame");

    // Ramp frame, bit-reverse request
    clear_all();
    fill(1'b0, 0);
    send(1'b1, B, t0);
    push_expected(1'b1);
    wait_out(N, "ramp bitrev");
    chk("ramp bitrev b0l1", out_q[1], BitrevOn ? 512 : 32);
    chk("ramp bitrev b0l2", out_q[2], BitrevOn ? 256 : 64);
    chk("ramp bitrev b0l3", out_q[3], BitrevOn ? 768 : 96);
    chk("ramp bitrev b31l31", out_q[N - 1], 1023);
    cmp_frames("ramp bitrev frame");

    // Back-to-back frames with mode switch
    clear_all();
    fill(1'b1, 0);
    send(1'b0, B, t0);
    push_expected(1'b0);
    fill(1'b0, 1024);
    send(1'b1, B, t1);
    push_expected(1'b1);
    wait_out(2 * N, "b2b");
    chk("b2b starts", start_q.size(), 2);
    chk("b2b first latency", start_q[0] - t0, B + 1);
    chk("b2b start spacing", start_q[1] - start_q[0], B);
    chk("b2b valid cycles", vcyc_q.size(), 2 * B);
    chk("b2b valid contiguous", vcyc_q[2 * B - 1] - vcyc_q[0], 2 * B - 1);
    cmp_frames("b2b frames");

    // Restart at beat 10: only the second frame may appear
    clear_all();
    fill(1'b1, 0);
    send(1'b0, 10, t0);
    fill(1'b1, 0);
    send(1'b1, B, t1);
    push_expected(1'b1);
    wait_out(N, "restart");
    repeat (B + 5) @(negedge clk);
    chk("restart total elems", out_q.size(), N);
    chk("restart starts", start_q.size(), 1);
    chk("restart latency", start_q[0] - t1, B + 1);
    cmp_frames("restart frame");

    // Random frames, random modes, small random gaps
    clear_all();
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      fill(1'b1, 0);
      k = int'($urandom_range(0, 1));
      send(k[0], B, t0);
      push_expected(k[0]);
    end
    wait_out(4 * N, "random");
    chk("random starts", start_q.size(), 4);
    cmp_frames("random frames");

    // Small configuration N=16, P=4, S=2
    sout_q.delete();
    sstart_q.delete();
    for (int b = 0; b < int'(SB); b++) begin
      @(negedge clk);
      if (b == 0) t0 = cyc + 1;
      sbus.in_start = (b == 0);
      for (int j = 0; j < int'(SP); j++) sbus.inData[j] = SDW'(b * SP + j);
    end
    @(negedge clk);
    sbus.in_start = 1'b0;
    k = 0;
    while (sout_q.size() < SN && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("small latency", sstart_q[0] - t0, SB + 1);
    for (int b = 0; b < int'(SB); b++) begin
      sobs = {sout_q[b * SP + 3], sout_q[b * SP + 2], sout_q[b * SP + 1], sout_q[b * SP]};
      sref = {sexp[b * SP + 3], sexp[b * SP + 2], sexp[b * SP + 1], sexp[b * SP]};
      chk($sformatf("small beat %0d", b), sobs, sref);
    end

    // Reset in the middle of readout
    clear_all();
    fill(1'b1, 0);
    send(1'b0, B, t0);
    k = 0;
    while (start_q.size() == 0 && k < 4 * int'(B)) begin
      @(negedge clk);
      k++;
    end
    chk("midreset readout began", start_q.size(), 1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_idle_outputs("midreset async");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_all();
    repeat (3 * B) @(negedge clk);
    chk("midreset no residual data", out_q.size(), 0);
    chk("midreset no residual start", start_q.size(), 0);

    // Normal operation resumes after reset
    clear_all();
    fill(1'b1, 0);
    send(1'b1, B, t0);
    push_expected(1'b1);
    wait_out(N, "post reset");
    chk("post reset latency", start_q[0] - t0, B + 1);
    cmp_frames("post reset frame");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ntt_stride_permutation.md
# ntt_stride_permutation

Parametrised streaming permutation stage for the NTT datapath. It accepts one frame of `FRAME_SIZE` coefficients, delivered `INPUT_PER_CYCLE` per cycle in natural order, and emits the same frame reordered by a compile-time stride permutation or, when enabled, a runtime-selected bit-reversal. It uses ping-pong frame buffers, so frames can be streamed back-to-back with no bubbles. It generalises the fixed per-stage permutation blocks, so a single module serves every stage through parameters.

## Interface
- `DATA_WIDTH_PER_INPUT`, 28, bits per coefficient
- `INPUT_PER_CYCLE`, 32, lanes per beat (P); power of two
- `FRAME_SIZE`, 1024, coefficients per frame (N); power of two, multiple of P, N/P ≥ 2
- `STRIDE`, 32, stride S; power of two, 2 ≤ S ≤ N/2
- `clk`  in  1  single clock; all logic rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `in_start`  in  1  one-cycle pulse, coincident with beat 0 of an input frame
- `in_mode`  in  1  0 = stride, 1 = bit-reverse; sampled only with `in_start`
- `inData`  in  P×DATA_WIDTH_PER_INPUT  unpacked array `[INPUT_PER_CYCLE-1:0]`; lane j of beat b = element b·P+j
- `outData`  out  P×DATA_WIDTH_PER_INPUT  permuted lanes, same layout
- `out_start`  out  1  one-cycle pulse with output beat 0
- `out_valid`  out  1  high for all B = N/P output beats of a frame

## Operation
- Permutation for output element k (0..N−1), where input element i means input index i:
  - Stride mode: out[k] = in[(k mod S)·(N/S) + ⌊k/S⌋].
  - Bit-reverse mode: out[k] = in[bitrev_log2N(k)].
- Buffers: two frame buffers, W and R roles.
  - Write side: an in_start-sampled edge writes beat 0 at address 0 of bank W and loads beat counter wcnt=1. Each following edge writes the next beat and increments wcnt.
  - After beat B−1 is written, the bank is marked full and wcnt returns to idle. The data in inData is ignored while idle.
- Mode is latched per frame and travels with the bank.
- Read FSM states:
  - IDLE: on a full bank, swap roles and go to READ with rcnt=0.
  - READ: present beat rcnt of bank R, permuted by that frame's mode. rcnt wraps at B−1.
  - At wrap, either start the next full bank immediately (back-to-back) or return to IDLE.
- Outputs are registered from the read-side permutation mux.
- Boundary conditions:
  - `in_start` while wcnt is mid-frame: the partial frame is discarded and capture restarts at beat 0 with the new mode. No output is produced for the discarded frame.
  - `in_start` on the edge immediately after beat B−1: accepted. Its frame goes to the other bank with no gap.
  - A bank is never overwritten while being read. The read rate equals the write rate, so the write bank is always free when needed.
  - `rst` asserted mid-frame: everything clears immediately, and partially written or partially read frames are lost.
- Reset values: `outData` all 0, `out_start` 0, `out_valid` 0, wcnt idle, FSM IDLE, bank-full flags 0.

## Timing
- Edge t0 samples `in_start`=1 together with beat 0. The last beat is sampled at t0+B−1.
- `out_start` and `out_valid` rise after edge t0+B+1. Latency is B+1 clocks from the in_start edge to the out_start edge.
- `out_start` is high for exactly 1 cycle. `out_valid` is high for B consecutive cycles.
- Back-to-back frames at t0 and t0+B produce a continuous `out_valid`, with `out_start` pulses B cycles apart.
- Throughput is one frame per B cycles, sustained.

## Configuration
- `NTT_PERM_BITREV_EN` defined: bit-reverse mode is available, and `in_mode`=1 selects it.
- `NTT_PERM_BITREV_EN` undefined: the bit-reverse logic is not compiled. `in_mode` is ignored and every frame uses stride mode.

## Test plan
- Reset check: assert `rst` for 2 cycles -> all outputs 0; no `out_start` without input.
- Default stride check: N=1024, P=32, S=32, in element i = i, `in_mode`=0 -> `out_start` B+1=33 edges after `in_start`; beat 0 lane j = 32·j; beat 1 lane j = 32·j+1; beat 31 lane 31 = 1023.
- Bit-reverse check (macro defined): same frame with `in_mode`=1 -> beat 0 lanes 0..3 = 0, 512, 256, 768; beat 31 lane 31 = 1023. With the macro undefined -> the stride result above.
- Small configuration: N=16, P=4, S=2, in = 0..15 -> output beats {0,8,1,9}, {2,10,3,11}, {4,12,5,13}, {6,14,7,15}.
- Back-to-back mode switching: frames A (stride) and B (bit-reverse, values +1024) sent with no gap -> `out_valid` high for 64 continuous cycles, `out_start` pulses 32 cycles apart, and each frame is permuted by its own mode.
- Restart and reset mid-operation: `in_start` again at beat 10 -> only the second frame is output. `rst` pulsed mid-readout -> outputs 0 on the next cycle, and no residual output follows.
